// File: rtl/regfile_sb.sv
// Two-write / two-read register file with a per-register pending (scoreboard) bit.
// Reads are combinational with write-through bypass; register 0 is hardwired to zero.

module regfile_sb_cell #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    input  logic            set_p,
    input  logic            clr_p,
    output logic [XLEN-1:0] q,
    output logic            pend,
    output logic            pend_nxt
);
    // An issue in the same cycle as the retiring write keeps the register pending.
    assign pend_nxt = set_p | (pend & ~clr_p);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q    <= '0;
            pend <= 1'b0;
        end else begin
            if (we) q <= wdata;
            pend <= pend_nxt;
        end
    end
endmodule

module regfile_sb #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    output logic            busy1,
    output logic            busy2,
    input  logic            wr0_en,
    input  logic [AW-1:0]   wr0_addr,
    input  logic [XLEN-1:0] wr0_data,
    input  logic            wr1_en,
    input  logic [AW-1:0]   wr1_addr,
    input  logic [XLEN-1:0] wr1_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    output logic            any_pending
);
    logic [NREG-1:0][XLEN-1:0] regs;
    logic [NREG-1:0]           hit0, hit1;
    logic [NREG-1:0]           pend, pend_nxt;

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign regs[i]     = '0;
            assign hit0[i]     = 1'b0;
            assign hit1[i]     = 1'b0;
            assign pend[i]     = 1'b0;
            assign pend_nxt[i] = 1'b0;
        end else begin : g_cell
            localparam logic [AW-1:0] IDX = AW'(i);
            assign hit0[i] = wr0_en && (wr0_addr == IDX);
            assign hit1[i] = wr1_en && (wr1_addr == IDX);

            regfile_sb_cell #(.XLEN(XLEN)) u_cell (
                .clk      (clk),
                .resetn   (resetn),
                .we       (hit0[i] | hit1[i]),
                .wdata    (hit1[i] ? wr1_data : wr0_data),
                .set_p    (issue_en && (issue_rd == IDX)),
                .clr_p    (hit0[i] | hit1[i]),
                .q        (regs[i]),
                .pend     (pend[i]),
                .pend_nxt (pend_nxt[i])
            );
        end
    end

    // Hit bits for index 0 are tied low, so rsX==0 never bypasses or reports busy.
    always_comb begin
        read_data1 = hit1[rs1] ? wr1_data : (hit0[rs1] ? wr0_data : regs[rs1]);
        read_data2 = hit1[rs2] ? wr1_data : (hit0[rs2] ? wr0_data : regs[rs2]);
        busy1      = pend[rs1] & ~hit0[rs1] & ~hit1[rs1];
        busy2      = pend[rs2] & ~hit0[rs2] & ~hit1[rs2];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) any_pending <= 1'b0;
        else         any_pending <= |pend_nxt;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Randomized self-checking bench for regfile_sb against a behavioural register/scoreboard model,
// plus directed scenarios with literal expectations and a 64-bit / 16-register instance.

module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  rs1, rs2, wr0_addr, wr1_addr, issue_rd;
    logic [31:0] wr0_data, wr1_data, read_data1, read_data2;
    logic        wr0_en, wr1_en, issue_en, busy1, busy2, any_pending;

    logic        b_resetn;
    logic [3:0]  b_rs1, b_rs2, b_wr0_addr, b_wr1_addr, b_issue_rd;
    logic [63:0] b_wr0_data, b_wr1_data, b_rd1, b_rd2;
    logic        b_wr0_en, b_wr1_en, b_issue_en, b_busy1, b_busy2, b_any;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .resetn(resetn), .rs1(rs1), .rs2(rs2),
        .read_data1(read_data1), .read_data2(read_data2), .busy1(busy1), .busy2(busy2),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .any_pending(any_pending)
    );

    regfile_sb #(.XLEN(64), .NREG(16)) dut_b (
        .clk(clk), .resetn(b_resetn), .rs1(b_rs1), .rs2(b_rs2),
        .read_data1(b_rd1), .read_data2(b_rd2), .busy1(b_busy1), .busy2(b_busy2),
        .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
        .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
        .issue_en(b_issue_en), .issue_rd(b_issue_rd), .any_pending(b_any)
    );

    // Behavioural model: register contents, set of outstanding destinations, registered OR.
    logic [31:0] m_reg [32];
    logic [31:0] m_pend, m_pend_nxt;
    logic        m_any;

    always_comb begin
        m_pend_nxt = m_pend;
        for (int i = 1; i < 32; i++) begin
            if (issue_en && issue_rd == 5'(i))
                m_pend_nxt[i] = 1'b1;
            else if ((wr0_en && wr0_addr == 5'(i)) || (wr1_en && wr1_addr == 5'(i)))
                m_pend_nxt[i] = 1'b0;
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) m_reg[i] <= '0;
            m_pend <= '0;
            m_any  <= 1'b0;
        end else begin
            if (wr0_en && wr0_addr != 0) m_reg[wr0_addr] <= wr0_data;
            if (wr1_en && wr1_addr != 0) m_reg[wr1_addr] <= wr1_data;  // later write wins
            m_pend <= m_pend_nxt;
            m_any  <= (m_pend_nxt != 0);
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] rs);
        if (rs == 0) return 32'h0;
        if (wr1_en && wr1_addr == rs) return wr1_data;
        if (wr0_en && wr0_addr == rs) return wr0_data;
        return m_reg[rs];
    endfunction

    function automatic logic exp_busy(input logic [4:0] rs);
        if (rs == 0) return 1'b0;
        return m_pend[rs] && !(wr0_en && wr0_addr == rs) && !(wr1_en && wr1_addr == rs);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_rd1",  64'(read_data1), 64'(exp_rd(rs1)));
            chk("m_rd2",  64'(read_data2), 64'(exp_rd(rs2)));
            chk("m_busy1", 64'(busy1), 64'(exp_busy(rs1)));
            chk("m_busy2", 64'(busy2), 64'(exp_busy(rs2)));
            chk("m_any",  64'(any_pending), 64'(m_any));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 0; wr1_en = 0; issue_en = 0;
        wr0_addr = 0; wr1_addr = 0; issue_rd = 0;
        wr0_data = 0; wr1_data = 0;
    endtask

    initial begin
        resetn = 0; rs1 = 5; rs2 = 0; idle();
        b_resetn = 0; b_rs1 = 0; b_rs2 = 0; b_wr0_en = 0; b_wr1_en = 0; b_issue_en = 0;
        b_wr0_addr = 0; b_wr1_addr = 0; b_issue_rd = 0; b_wr0_data = 0; b_wr1_data = 0;
        #2;
        chk_en = 1;
        tick(); tick();
        resetn = 1; b_resetn = 1;

        // Clean state after reset
        @(negedge clk);
        chk("rst_rd1", 64'(read_data1), 64'h0);
        chk("rst_rd2", 64'(read_data2), 64'h0);
        chk("rst_busy", 64'({busy1, busy2}), 64'h0);
        chk("rst_any", 64'(any_pending), 64'h0);

        // Dual write to the same register: port 1 wins, also through bypass
        tick();
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'hAAAA0000;
        wr1_en = 1; wr1_addr = 3; wr1_data = 32'h5555FFFF; rs1 = 3;
        @(negedge clk); chk("dual_byp", 64'(read_data1), 64'h5555FFFF);
        tick(); idle();
        @(negedge clk); chk("dual_store", 64'(read_data1), 64'h5555FFFF);

        // Issue, busy, writeback resolves busy and clears pending
        tick(); issue_en = 1; issue_rd = 7;
        tick(); idle(); rs1 = 7;
        @(negedge clk);
        chk("iss_busy", 64'(busy1), 64'h1);
        chk("iss_any", 64'(any_pending), 64'h1);
        tick(); wr1_en = 1; wr1_addr = 7; wr1_data = 32'h12345678;
        @(negedge clk);
        chk("wb_busy", 64'(busy1), 64'h0);
        chk("wb_rd", 64'(read_data1), 64'h12345678);
        tick(); idle();
        @(negedge clk);
        chk("wb_busy_after", 64'(busy1), 64'h0);
        chk("wb_any_after", 64'(any_pending), 64'h0);

        // Issue and write to the same pending register: issue wins
        tick(); issue_en = 1; issue_rd = 9;
        tick(); wr0_en = 1; wr0_addr = 9; wr0_data = 32'hCAFE0009;
        tick(); idle(); rs1 = 9;
        @(negedge clk);
        chk("issw_busy", 64'(busy1), 64'h1);
        chk("issw_rd", 64'(read_data1), 64'hCAFE0009);

        // Register 0 ignores writes and issues
        tick(); wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF; issue_en = 1; issue_rd = 0; rs1 = 0;
        @(negedge clk);
        chk("r0_rd", 64'(read_data1), 64'h0);
        chk("r0_busy", 64'(busy1), 64'h0);
        tick(); idle();
        @(negedge clk);
        chk("r0_rd_next", 64'(read_data1), 64'h0);
        chk("r0_any", 64'(any_pending), 64'h1);

        // Async reset between edges wipes data and pending state
        tick(); issue_en = 1; issue_rd = 4; wr0_en = 1; wr0_addr = 4; wr0_data = 32'h1;
        tick(); idle(); rs1 = 4;
        @(negedge clk);
        chk("pre_rst_rd", 64'(read_data1), 64'h1);
        chk("pre_rst_busy", 64'(busy1), 64'h1);
        #1 resetn = 0;
        #1;
        chk("arst_rd", 64'(read_data1), 64'h0);
        chk("arst_busy", 64'(busy1), 64'h0);
        chk("arst_any", 64'(any_pending), 64'h0);
        tick(); resetn = 1;

        // Wide instance: dual write to same register
        tick();
        b_wr0_en = 1; b_wr0_addr = 3; b_wr0_data = 64'hAAAA0000_11112222;
        b_wr1_en = 1; b_wr1_addr = 3; b_wr1_data = 64'h5555FFFF_33334444; b_rs1 = 3;
        @(negedge clk); chk("b_dual_byp", b_rd1, 64'h5555FFFF_33334444);
        tick(); b_wr0_en = 0; b_wr1_en = 0;
        @(negedge clk);
        chk("b_dual_store", b_rd1, 64'h5555FFFF_33334444);
        chk("b_any", 64'(b_any), 64'h0);

        // Random traffic over a narrow address window to force collisions
        for (int n = 0; n < 3000; n++) begin
            tick();
            resetn   = ($urandom_range(0, 59) != 0);
            wr0_en   = $urandom_range(0, 1);
            wr1_en   = $urandom_range(0, 1);
            issue_en = $urandom_range(0, 2) != 0;
            wr0_addr = 5'($urandom_range(0, (n % 2) ? 31 : 7));
            wr1_addr = 5'($urandom_range(0, (n % 2) ? 31 : 7));
            issue_rd = 5'($urandom_range(0, (n % 2) ? 31 : 7));
            rs1      = 5'($urandom_range(0, (n % 3) ? 7 : 31));
            rs2      = 5'($urandom_range(0, 31));
            wr0_data = $urandom;
            wr1_data = $urandom;
        end
        tick(); resetn = 1; idle();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
